xgs_axis_frame_monitor: RTL and testbench
=========================================

Name: xgs_axis_frame_monitor

Overview:
Passive, non-intrusive monitor on the XGS sensor-to-host AXI4-Stream: 64-bit data, 4-bit tuser, i.e. the stream feeding the DMA.
- Sniffs tvalid/tready/tlast/tuser/tdata without driving the handshake.
- Checks frame/line framing and measures frame geometry.
- Raises a one-cycle end-of-frame pulse plus sticky error flags, readable by the register file.

Parameters:
AXIS_DATA_WIDTH, 64, tdata width; only used by the optional checksum.
AXIS_USER_WIDTH, 4, tuser width; must be 4.
CNT_WIDTH, 16, width of the line and beat counters.

Ports:
aclk  in  1  stream/register clock
aclk_reset  in  1  synchronous, active-high reset
enable  in  1  1 = monitor active; 0 = ignore the stream and hold FSM in S_IDLE
err_clr  in  1  one-cycle pulse; clears err_flags
s_axis_tvalid  in  1  sniffed tvalid
s_axis_tready  in  1  sniffed tready
s_axis_tlast  in  1  sniffed tlast
s_axis_tuser  in  4  sniffed tuser: [0]=SOF, [1]=EOF, [2]=SOL, [3]=EOL
s_axis_tdata  in  AXIS_DATA_WIDTH  sniffed tdata
frame_count  out  32  completed frames, wraps 0xFFFFFFFF->0
last_line_count  out  CNT_WIDTH  lines in the last completed frame
last_line_beats  out  CNT_WIDTH  beats per line in the last completed frame (width of first line)
eof_pulse  out  1  one cycle after each accepted EOF beat
err_flags  out  5  sticky: [0] SOF inside frame, [1] beat outside frame, [2] line width mismatch, [3] EOL/tlast disagreement, [4] counter overflow
frame_checksum  out  32  see Optional Feature

Behaviour:
- Beat = s_axis_tvalid & s_axis_tready, sampled on rising aclk. Non-beat cycles have no effect.
- Reset (aclk_reset=1): all outputs 0; FSM to S_IDLE; internal counters 0. Reset mid-frame discards the partial frame.
- Line rules:
  - SOF implies SOL.
  - EOL beat must carry tlast, and tlast must only be on EOL beats; otherwise set err[3].
  - EOF implies EOL.
- FSM states: S_IDLE, S_IN_LINE, S_GAP.
  - S_IDLE: a beat with SOF -> S_IN_LINE, line_cnt=0, beat_cnt=1, ref_beats=0. Any other beat sets err[1] and stays. A beat with SOF and EOL (1-beat line) closes the line immediately: go to S_GAP, or finish the frame if EOF is also set.
  - S_IN_LINE: every beat increments beat_cnt (saturating; saturation sets err[4]).
    - SOF beat: sets err[0] and restarts the frame as if from S_IDLE.
    - EOL beat: line_cnt+1. If it is the first line, ref_beats=beat_cnt; else if beat_cnt!=ref_beats, set err[2]. Then go to S_GAP, or finish the frame if EOF.
  - S_GAP: a beat with SOL -> S_IN_LINE with beat_cnt=1 (EOL on the same beat handled as above). A beat with SOF sets err[0] and restarts. A beat without SOL sets err[1] and is dropped.
- Frame finish, at the EOF beat: next cycle frame_count+1, last_line_count=line_cnt (inclusive of this line), last_line_beats=ref_beats, eof_pulse=1 for exactly one cycle; FSM -> S_IDLE.
- Latency: beat -> status outputs = 1 cycle (registered).
- err_flags:
  - A set and err_clr in the same cycle: set wins.
  - Otherwise err_clr clears all bits on the next cycle.
- enable deassert mid-frame: FSM -> S_IDLE next cycle, no counters updated, no errors flagged. enable does not clear frame_count.
- line_cnt saturates at all-ones and sets err[4].

Optional Feature:
Macro: XGS_FRAME_CHECKSUM_EN.
- Defined:
  - Running 32-bit sum (mod 2^32) of every beat's tdata, folded as the sum of its 32-bit halves (lower + upper). It covers SOF through EOF inclusive.
  - The sum is cleared at SOF.
  - frame_checksum is updated together with frame_count.
- Not defined: frame_checksum tied to 0; no adder logic.

Test Plan:
- Frame of 4 lines x 8 beats, tready always 1, tdata=beat index -> frame_count=1, last_line_count=4, last_line_beats=8, single eof_pulse, err_flags=0; with macro, frame_checksum=4*28=112.
- Same frame with tready toggling 1/0 every cycle and tvalid held -> identical results; non-beat cycles ignored.
- Line 3 is 7 beats instead of 8 -> err_flags=5'b00100, frame still counted (frame_count=1); err_clr pulse -> err_flags=0.
- SOF inside line 2, then a clean 2x4 frame -> err[0] set, frame_count=1, last_line_count=2, last_line_beats=4.
- Beat with no SOF while idle, then tlast on a non-EOL beat -> err[1] and err[3] set, frame_count unchanged.
- aclk_reset asserted mid-frame, then a clean 1x1 frame (SOF|SOL|EOL|EOF in one beat) -> frame_count=1, last_line_count=1, last_line_beats=1, no errors.

Source files
------------

// File: rtl/xgs_axis_frame_monitor.sv
// xgs_axis_frame_monitor: passive AXI4-Stream frame/line checker and geometry meter; optional checksum via XGS_FRAME_CHECKSUM_EN
module xgs_axis_frame_monitor #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       aclk,
  input  logic                       aclk_reset,
  input  logic                       enable,
  input  logic                       err_clr,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  output logic [31:0]                frame_count,
  output logic [CNT_WIDTH-1:0]       last_line_count,
  output logic [CNT_WIDTH-1:0]       last_line_beats,
  output logic                       eof_pulse,
  output logic [4:0]                 err_flags,
  output logic [31:0]                frame_checksum
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  typedef enum logic [1:0] {S_IDLE, S_IN_LINE, S_GAP} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] line_cnt, line_cnt_n, beat_cnt, beat_cnt_n, ref_beats, ref_beats_n;
  logic [CNT_WIDTH-1:0] lc, rb, b;
  logic [4:0] err_set;
  logic beat, sof, sol, eol, eof, take, fin;
  assign beat = enable & s_axis_tvalid & s_axis_tready;
  assign sof  = s_axis_tuser[0];
  assign eof  = s_axis_tuser[1];
  assign sol  = s_axis_tuser[2] | sof;
  assign eol  = s_axis_tuser[3] | eof;
  // next-state: a SOF always restarts the frame; an accepted EOL beat closes the line
  always_comb begin
    state_n     = enable ? state : S_IDLE;
    line_cnt_n  = line_cnt;
    beat_cnt_n  = beat_cnt;
    ref_beats_n = ref_beats;
    err_set     = '0;
    take        = 1'b0;
    fin         = 1'b0;
    lc          = line_cnt;
    rb          = ref_beats;
    b           = beat_cnt;
    if (beat) begin
      err_set[3] = eol != s_axis_tlast;
      if (sof) begin
        err_set[0] = state != S_IDLE;
        take       = 1'b1;
        lc         = '0;
        rb         = '0;
        b          = ONE;
      end else if (state == S_IN_LINE) begin
        take       = 1'b1;
        err_set[4] = &beat_cnt;
        b          = &beat_cnt ? beat_cnt : beat_cnt + ONE;
      end else if (state == S_GAP && sol) begin
        take = 1'b1;
        b    = ONE;
      end else begin
        err_set[1] = 1'b1;
      end
      if (take) begin
        state_n     = S_IN_LINE;
        beat_cnt_n  = b;
        line_cnt_n  = lc;
        ref_beats_n = rb;
        if (eol) begin
          err_set[4]  = err_set[4] | (&lc);
          line_cnt_n  = &lc ? lc : lc + ONE;
          ref_beats_n = (lc == '0) ? b : rb;
          err_set[2]  = (lc != '0) && (b != rb);
          state_n     = eof ? S_IDLE : S_GAP;
          fin         = eof;
        end
      end
    end
  end
  // state, counters and registered status outputs
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state           <= S_IDLE;
      line_cnt        <= '0;
      beat_cnt        <= '0;
      ref_beats       <= '0;
      frame_count     <= '0;
      last_line_count <= '0;
      last_line_beats <= '0;
      eof_pulse       <= 1'b0;
      err_flags       <= '0;
    end else begin
      state     <= state_n;
      line_cnt  <= line_cnt_n;
      beat_cnt  <= beat_cnt_n;
      ref_beats <= ref_beats_n;
      eof_pulse <= fin;
      err_flags <= (err_clr ? 5'd0 : err_flags) | err_set;
      if (fin) begin
        frame_count     <= frame_count + 32'd1;
        last_line_count <= line_cnt_n;
        last_line_beats <= ref_beats_n;
      end
    end
  end
`ifdef XGS_FRAME_CHECKSUM_EN
  logic [31:0] sum, sum_n;
  assign sum_n = (sof ? 32'd0 : sum) + s_axis_tdata[31:0] + s_axis_tdata[63:32];
  // running sum over accepted frame beats, published at frame end
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      sum            <= '0;
      frame_checksum <= '0;
    end else begin
      if (take) sum <= sum_n;
      if (fin) frame_checksum <= sum_n;
    end
  end
`else
  logic unused_tdata;
  assign unused_tdata   = ^s_axis_tdata;
  assign frame_checksum = '0;
`endif
endmodule

// File: tb/tb_xgs_axis_frame_monitor.sv
// tb_xgs_axis_frame_monitor: table-driven, directed and random checks against a frame-level model
module tb_xgs_axis_frame_monitor;
  logic aclk = 1'b0, aclk_reset = 1'b1, enable = 1'b1, err_clr = 1'b0;
  logic s_axis_tvalid = 1'b0, s_axis_tready = 1'b0, s_axis_tlast = 1'b0;
  logic [3:0] s_axis_tuser = '0;
  logic [63:0] s_axis_tdata = '0;
  logic [31:0] frame_count, frame_checksum;
  logic [15:0] last_line_count, last_line_beats;
  logic eof_pulse;
  logic [4:0] err_flags;

  xgs_axis_frame_monitor dut (
    .aclk(aclk), .aclk_reset(aclk_reset), .enable(enable), .err_clr(err_clr),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tdata(s_axis_tdata),
    .frame_count(frame_count), .last_line_count(last_line_count), .last_line_beats(last_line_beats),
    .eof_pulse(eof_pulse), .err_flags(err_flags), .frame_checksum(frame_checksum)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0, pulse_cnt = 0;

  // frame-level reference: a frame is a list of line widths
  bit m_in_frame, m_in_line, m_pulse;
  int m_widths[$];
  int m_cur;
  logic [31:0] m_fc, m_sum, m_cks;
  logic [15:0] m_llc, m_llb;
  logic [4:0] m_err;

  function automatic void model_reset();
    m_in_frame = 0; m_in_line = 0; m_pulse = 0; m_widths = {}; m_cur = 0;
    m_fc = 0; m_sum = 0; m_cks = 0; m_llc = 0; m_llb = 0; m_err = 0;
  endfunction

  function automatic void model_beat(logic [3:0] u, logic l, logic [63:0] d);
    bit sof = u[0], eof = u[1], sol = u[2] | u[0], eol = u[3] | u[1];
    if (eol != l) m_err[3] = 1;
    if (sof) begin
      if (m_in_frame) m_err[0] = 1;
      m_in_frame = 1; m_in_line = 1; m_widths = {}; m_cur = 0; m_sum = 0;
    end else if (!m_in_frame) begin
      m_err[1] = 1; return;
    end else if (!m_in_line) begin
      if (!sol) begin m_err[1] = 1; return; end
      m_in_line = 1; m_cur = 0;
    end
    m_cur++;
    m_sum += d[31:0] + d[63:32];
    if (eol) begin
      m_widths.push_back(m_cur);
      if (m_cur != m_widths[0]) m_err[2] = 1;
      m_in_line = 0;
      if (eof) begin
        m_fc++; m_llc = 16'(m_widths.size()); m_llb = 16'(m_widths[0]);
        m_cks = m_sum; m_pulse = 1; m_in_frame = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("fc", frame_count, m_fc);
    chk("pulse", 32'(eof_pulse), 32'(m_pulse));
    chk("err", 32'(err_flags), 32'(m_err));
    chk("llc", 32'(last_line_count), 32'(m_llc));
    chk("llb", 32'(last_line_beats), 32'(m_llb));
`ifdef XGS_FRAME_CHECKSUM_EN
    chk("cks", frame_checksum, m_cks);
`else
    chk("cks", frame_checksum, 32'd0);
`endif
  endtask

  task automatic cyc(input logic v, input logic r, input logic [3:0] u, input logic l,
                     input logic [63:0] d, input logic clr, input logic en);
    @(negedge aclk);
    s_axis_tvalid = v; s_axis_tready = r; s_axis_tuser = u; s_axis_tlast = l;
    s_axis_tdata = d; err_clr = clr; enable = en;
    @(posedge aclk);
    m_pulse = 0;
    if (clr) m_err = 0;
    if (!en) begin m_in_frame = 0; m_in_line = 0; end
    else if (v && r) model_beat(u, l, d);
    #1;
    if (eof_pulse) pulse_cnt++;
    chk_model();
  endtask

  task automatic idle(input logic clr);
    cyc(0, 0, 4'h0, 0, 64'd0, clr, 1);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aclk_reset = 1; s_axis_tvalid = 0; err_clr = 0; enable = 1;
    @(posedge aclk); #1;
    model_reset();
    chk("rst_fc", frame_count, 32'd0);
    chk("rst_pulse", 32'(eof_pulse), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    chk("rst_llc", 32'(last_line_count), 32'd0);
    chk("rst_llb", 32'(last_line_beats), 32'd0);
    chk("rst_cks", frame_checksum, 32'd0);
    @(negedge aclk);
    aclk_reset = 0;
  endtask

  // mode 0: tready high; 1: tready low then high per beat; 2: random tready
  task automatic send_beat(input logic [3:0] u, input logic l, input logic [63:0] d, input int mode);
    logic r;
    if (mode == 1) cyc(1, 0, u, l, d, 0, 1);
    if (mode == 2) begin
      r = 1'($urandom_range(0, 2) != 0);
      while (!r) begin
        cyc(1, 0, u, l, d, 0, 1);
        r = 1'($urandom_range(0, 2) != 0);
      end
    end
    cyc(1, 1, u, l, d, 0, 1);
  endtask

  task automatic send_frame(input int nlines, input int width, input int short_line, input int mode);
    for (int ln = 0; ln < nlines; ln++) begin
      int w = (ln == short_line) ? width - 1 : width;
      for (int i = 0; i < w; i++) begin
        bit e = (i == w - 1);
        send_beat({e, i == 0, e && ln == nlines - 1, ln == 0 && i == 0}, e, 64'(i), mode);
      end
    end
  endtask

  typedef struct {
    int nlines; int width; int short_line; int mode;
    logic [15:0] llc; logic [15:0] llb; logic [4:0] err; logic [31:0] cks;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{4, 8, -1, 0, 16'd4, 16'd8, 5'b00000, 32'd112};
    tbl[1] = '{4, 8, -1, 1, 16'd4, 16'd8, 5'b00000, 32'd112};
    tbl[2] = '{4, 8,  2, 0, 16'd4, 16'd8, 5'b00100, 32'd105};
    tbl[3] = '{1, 1, -1, 0, 16'd1, 16'd1, 5'b00000, 32'd0};
    tbl[4] = '{3, 5, -1, 1, 16'd3, 16'd5, 5'b00000, 32'd30};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(1);
      pulse_cnt = 0;
      send_frame(tbl[i].nlines, tbl[i].width, tbl[i].short_line, tbl[i].mode);
      idle(0);
      idle(0);
      chk("tbl_fc", frame_count, 32'(i + 1));
      chk("tbl_llc", 32'(last_line_count), 32'(tbl[i].llc));
      chk("tbl_llb", 32'(last_line_beats), 32'(tbl[i].llb));
      chk("tbl_err", 32'(err_flags), 32'(tbl[i].err));
      chk("tbl_pulses", 32'(pulse_cnt), 32'd1);
`ifdef XGS_FRAME_CHECKSUM_EN
      chk("tbl_cks", frame_checksum, tbl[i].cks);
`endif
      idle(1);
      chk("tbl_clr", 32'(err_flags), 32'd0);
    end

    // SOF inside line 2, then a clean 2x4 frame
    send_beat(4'b0101, 0, 64'd0, 0);
    for (int i = 1; i < 7; i++) send_beat(4'b0000, 0, 64'(i), 0);
    send_beat(4'b1000, 1, 64'd7, 0);
    send_beat(4'b0100, 0, 64'd0, 0);
    send_beat(4'b0000, 0, 64'd1, 0);
    send_frame(2, 4, -1, 0);
    idle(0);
    chk("sofin_fc", frame_count, 32'd6);
    chk("sofin_llc", 32'(last_line_count), 32'd2);
    chk("sofin_llb", 32'(last_line_beats), 32'd4);
    chk("sofin_err", 32'(err_flags), 32'b00001);
    idle(1);

    // stray beat while idle, then tlast on a non-EOL beat
    send_beat(4'b0100, 0, 64'd9, 0);
    send_beat(4'b0001, 1, 64'd9, 0);
    idle(0);
    chk("stray_err", 32'(err_flags), 32'b01010);
    chk("stray_fc", frame_count, 32'd6);

    // a new error arriving with err_clr survives the clear
    idle(0);
    cyc(1, 1, 4'b0001, 0, 64'd0, 1, 1);
    chk("clrset_err", 32'(err_flags), 32'b00001);

    // reset mid-frame, then a single-beat frame
    send_beat(4'b0000, 0, 64'd3, 0);
    do_reset();
    send_beat(4'b1111, 1, 64'h0000_0002_0000_0005, 0);
    idle(0);
    chk("one_fc", frame_count, 32'd1);
    chk("one_llc", 32'(last_line_count), 32'd1);
    chk("one_llb", 32'(last_line_beats), 32'd1);
    chk("one_err", 32'(err_flags), 32'd0);
`ifdef XGS_FRAME_CHECKSUM_EN
    chk("one_cks", frame_checksum, 32'd7);
`endif

    // enable dropped mid-frame: garbage ignored, monitor idles
    send_beat(4'b0101, 0, 64'd0, 0);
    cyc(1, 1, 4'b1010, 0, 64'd1, 0, 0);
    chk("en_err", 32'(err_flags), 32'd0);
    send_beat(4'b1010, 1, 64'd2, 0);
    chk("en_fc", frame_count, 32'd1);
    chk("en_stray", 32'(err_flags), 32'b00010);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 9);
      if (kind < 7)
        send_frame($urandom_range(1, 4), $urandom_range(1, 6),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, 2);
      else if (kind == 7)
        repeat ($urandom_range(1, 4))
          cyc(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
              {32'($urandom), 32'($urandom)}, 0, 1);
      else if (kind == 8)
        idle(1);
      else
        cyc(1, 1, 4'($urandom), 1'($urandom), 64'($urandom), 0, 0);
    end
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
